// File: rtl/controle_sentido_pkg.sv
// Shared encodings for the turn-key conditioning path: headings, turn codes and
// debounce filter states.
package controle_sentido_pkg;

    typedef enum logic [1:0] {
        DIR_DIREITA  = 2'd0,
        DIR_BAIXO    = 2'd1,
        DIR_ESQUERDA = 2'd2,
        DIR_CIMA     = 2'd3
    } dir_t;

    typedef enum logic {
        GIRO_AH = 1'b0,
        GIRO_H  = 1'b1
    } giro_t;

    typedef enum logic [1:0] {
        SOLTO       = 2'd0,
        CONF_PRESS  = 2'd1,
        PRESSIONADO = 2'd2,
        CONF_SOLTA  = 2'd3
    } filtro_estado_t;

    // Heading after one turn; the 2-bit arithmetic provides the mod-4 wrap.
    function automatic logic [1:0] aplica_giro(input logic [1:0] s, input giro_t g);
        logic [1:0] r;
        if (g == GIRO_H) r = s + 2'd1;
        else             r = s - 2'd1;
        return r;
    endfunction

endpackage

// File: rtl/controle_sentido_filtro_tecla.sv
// Two-flop synchronizer plus debounce FSM for one active-low key; emits a
// one-cycle pulse when a press is confirmed (releases produce nothing).
module filtro_tecla
    import controle_sentido_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key_n,
    output logic o_press
);

    localparam int unsigned    CW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  LIMITE = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]     r_sync;
    filtro_estado_t r_estado;
    logic [CW-1:0]  r_cnt;
    logic           r_press;
    logic           w_nivel;

    assign w_nivel = r_sync[1];
    assign o_press = r_press;

    // The sample that leaves a stable state counts as the first of the run.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync   <= '1;
            r_estado <= SOLTO;
            r_cnt    <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_key_n};
            r_press <= 1'b0;
            case (r_estado)
                SOLTO: begin
                    if (!w_nivel) begin
                        r_estado <= CONF_PRESS;
                        r_cnt    <= CW'(1);
                    end
                end
                CONF_PRESS: begin
                    if (w_nivel) begin
                        r_estado <= SOLTO;
                        r_cnt    <= '0;
                    end else if (r_cnt >= LIMITE) begin
                        r_estado <= PRESSIONADO;
                        r_cnt    <= '0;
                        r_press  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                PRESSIONADO: begin
                    if (w_nivel) begin
                        r_estado <= CONF_SOLTA;
                        r_cnt    <= CW'(1);
                    end
                end
                CONF_SOLTA: begin
                    if (!w_nivel) begin
                        r_estado <= PRESSIONADO;
                        r_cnt    <= '0;
                    end else if (r_cnt >= LIMITE) begin
                        r_estado <= SOLTO;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_estado <= SOLTO;
                    r_cnt    <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/controle_sentido.sv
// Debounces the two turn keys, queues accepted turns and applies one turn per
// game step to the registered player heading.
module controle_sentido
    import controle_sentido_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned FIFO_DEPTH      = 2,
    parameter logic [1:0]  SENTIDO_INICIAL = DIR_DIREITA
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       reiniciar,
    input  logic       key_ah_n,
    input  logic       key_h_n,
    input  logic       passo,
    output logic [1:0] sentido,
    output logic       giro_pendente,
    output logic       giro_descartado
);

    localparam int unsigned AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNTW = $clog2(FIFO_DEPTH + 1);

    logic            w_ev_ah;
    logic            w_ev_h;
    logic            w_evento;
    giro_t           w_cmd;
    logic            w_vazia;
    logic            w_cheia;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;

    giro_t           r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr;
    logic [AW-1:0]   r_rd;
    logic [CNTW-1:0] r_count;
    logic [1:0]      r_sentido;
    logic            r_descartado;

    filtro_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_ah (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_key_n (key_ah_n),
        .o_press (w_ev_ah)
    );

    filtro_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filtro_h (
        .i_clk   (CLOCK_50),
        .i_rst   (reset),
        .i_key_n (key_h_n),
        .o_press (w_ev_h)
    );

    // Simultaneous presses cancel: neither enqueued nor counted as a drop.
    always_comb begin
        w_evento = w_ev_ah ^ w_ev_h;
        w_cmd    = w_ev_h ? GIRO_H : GIRO_AH;
        w_vazia  = (r_count == '0);
        w_cheia  = (r_count == CNTW'(FIFO_DEPTH));
        w_pop    = passo & ~w_vazia;
        w_push   = w_evento & (~w_cheia | w_pop);
        w_drop   = w_evento & w_cheia & ~w_pop;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= GIRO_AH;
            r_wr         <= '0;
            r_rd         <= '0;
            r_count      <= '0;
            r_sentido    <= SENTIDO_INICIAL;
            r_descartado <= 1'b0;
        end else if (reiniciar) begin
            r_wr         <= '0;
            r_rd         <= '0;
            r_count      <= '0;
            r_sentido    <= SENTIDO_INICIAL;
            r_descartado <= 1'b0;
        end else begin
            r_descartado <= w_drop;
            if (w_push) begin
                r_mem[r_wr] <= w_cmd;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_pop) begin
                r_rd      <= r_rd + AW'(1);
                r_sentido <= aplica_giro(r_sentido, r_mem[r_rd]);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNTW'(1);
                2'b01:   r_count <= r_count - CNTW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign sentido         = r_sentido;
    assign giro_pendente   = (r_count != '0);
    assign giro_descartado = r_descartado;

endmodule

// File: tb/tb_controle_sentido.sv
// Scoreboard bench for controle_sentido: expected turns are queued when a press
// is driven and consumed when passo is applied.
module tb_controle_sentido;

    localparam int unsigned D     = 4;
    localparam int unsigned DEPTH = 2;

    logic       CLOCK_50 = 1'b0;
    logic       reset;
    logic       reiniciar;
    logic       key_ah_n;
    logic       key_h_n;
    logic       passo;
    logic [1:0] sentido;
    logic       giro_pendente;
    logic       giro_descartado;

    int   n_total = 0;
    int   n_pass  = 0;
    bit   exp_q[$];
    logic [1:0] exp_sentido = 2'd0;

    controle_sentido #(
        .DEBOUNCE_CYCLES (D),
        .FIFO_DEPTH      (DEPTH),
        .SENTIDO_INICIAL (2'd0)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset           (reset),
        .reiniciar       (reiniciar),
        .key_ah_n        (key_ah_n),
        .key_h_n         (key_h_n),
        .passo           (passo),
        .sentido         (sentido),
        .giro_pendente   (giro_pendente),
        .giro_descartado (giro_descartado)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    function automatic logic [1:0] turn(input logic [1:0] s, input bit h);
        return h ? s + 2'd1 : s - 2'd1;
    endfunction

    task automatic hard_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_sentido = 2'd0;
    endtask

    // Full press/release of one key; checks the drop pulse against the model.
    task automatic press(input bit is_h);
        int drops;
        bit expect_drop;
        expect_drop = (exp_q.size() == DEPTH);
        drops = 0;
        if (is_h) key_h_n = 1'b0; else key_ah_n = 1'b0;
        repeat (8) begin tick(); if (giro_descartado) drops++; end
        key_h_n  = 1'b1;
        key_ah_n = 1'b1;
        repeat (8) begin tick(); if (giro_descartado) drops++; end
        if (!expect_drop) exp_q.push_back(is_h);
        n_total++;
        if (drops !== int'(expect_drop))
            $display("FAIL press_drop: got %0d pulses, expected %0d", drops, expect_drop);
        else n_pass++;
        n_total++;
        if (giro_pendente !== (exp_q.size() != 0))
            $display("FAIL press_pendente: got %0b, expected %0b", giro_pendente, exp_q.size() != 0);
        else n_pass++;
    endtask

    task automatic step();
        passo = 1'b1;
        tick();
        passo = 1'b0;
        if (exp_q.size() != 0) exp_sentido = turn(exp_sentido, exp_q.pop_front());
        n_total++;
        if (sentido !== exp_sentido)
            $display("FAIL step_sentido: got %0d, expected %0d", sentido, exp_sentido);
        else n_pass++;
        n_total++;
        if (giro_pendente !== (exp_q.size() != 0))
            $display("FAIL step_pendente: got %0b, expected %0b", giro_pendente, exp_q.size() != 0);
        else n_pass++;
    endtask

    task automatic test_reset();
        press(1'b1);
        step();
        press(1'b1);
        #3;
        reset = 1'b1;
        key_h_n = 1'b0;
        #1;
        exp_q.delete();
        exp_sentido = 2'd0;
        n_total++;
        if (sentido !== 2'd0 || giro_pendente !== 1'b0)
            $display("FAIL reset_async: got sentido=%0d pend=%0b, expected 0/0", sentido, giro_pendente);
        else n_pass++;
        tick();
        tick();
        reset = 1'b0;
        repeat (D + 2) tick();
        n_total++;
        if (giro_pendente !== 1'b0)
            $display("FAIL reset_held_early: got %0b, expected 0", giro_pendente);
        else n_pass++;
        tick();
        exp_q.push_back(1'b1);
        n_total++;
        if (giro_pendente !== 1'b1)
            $display("FAIL reset_held_accept: got %0b, expected 1", giro_pendente);
        else n_pass++;
        repeat (10) tick();
        key_h_n = 1'b1;
        repeat (10) tick();
        step();
    endtask

    task automatic test_bounce();
        hard_reset();
        for (int i = 0; i < 10; i++) begin
            key_h_n = i[0];
            tick();
            tick();
        end
        key_h_n = 1'b0;
        repeat (10) tick();
        key_h_n = 1'b1;
        repeat (10) tick();
        exp_q.push_back(1'b1);
        step();
        step();
    endtask

    task automatic test_wrap();
        hard_reset();
        repeat (3) begin
            press(1'b0);
            step();
        end
        press(1'b1);
        step();
    endtask

    task automatic test_overflow();
        hard_reset();
        repeat (3) press(1'b1);
        repeat (3) step();
    endtask

    task automatic test_simultaneous();
        int drops;
        hard_reset();
        drops = 0;
        key_h_n  = 1'b0;
        key_ah_n = 1'b0;
        repeat (10) begin tick(); if (giro_descartado) drops++; end
        key_h_n  = 1'b1;
        key_ah_n = 1'b1;
        repeat (10) begin tick(); if (giro_descartado) drops++; end
        n_total++;
        if (drops !== 0 || giro_pendente !== 1'b0)
            $display("FAIL simult_cancel: got drops=%0d pend=%0b, expected 0/0", drops, giro_pendente);
        else n_pass++;
        press(1'b0);
        press(1'b1);
        drops = 0;
        key_h_n = 1'b0;
        repeat (D + 2) begin tick(); if (giro_descartado) drops++; end
        passo = 1'b1;
        tick();
        passo = 1'b0;
        exp_sentido = turn(exp_sentido, exp_q.pop_front());
        exp_q.push_back(1'b1);
        repeat (6) begin tick(); if (giro_descartado) drops++; end
        key_h_n = 1'b1;
        repeat (8) tick();
        n_total++;
        if (drops !== 0)
            $display("FAIL full_push_pop_drop: got %0d pulses, expected 0", drops);
        else n_pass++;
        n_total++;
        if (sentido !== exp_sentido)
            $display("FAIL full_push_pop_sentido: got %0d, expected %0d", sentido, exp_sentido);
        else n_pass++;
        step();
        step();
        step();
    endtask

    task automatic test_restart();
        hard_reset();
        press(1'b1);
        step();
        press(1'b1);
        press(1'b0);
        reiniciar = 1'b1;
        tick();
        reiniciar = 1'b0;
        exp_q.delete();
        exp_sentido = 2'd0;
        n_total++;
        if (giro_pendente !== 1'b0 || sentido !== 2'd0)
            $display("FAIL restart_flush: got pend=%0b sentido=%0d, expected 0/0", giro_pendente, sentido);
        else n_pass++;
        key_h_n = 1'b0;
        repeat (10) tick();
        reiniciar = 1'b1;
        tick();
        reiniciar = 1'b0;
        repeat (12) tick();
        n_total++;
        if (giro_pendente !== 1'b0)
            $display("FAIL restart_held: got %0b, expected 0", giro_pendente);
        else n_pass++;
        key_h_n = 1'b1;
        repeat (10) tick();
        press(1'b1);
        step();
    endtask

    initial begin
        reset     = 1'b1;
        reiniciar = 1'b0;
        key_ah_n  = 1'b1;
        key_h_n   = 1'b1;
        passo     = 1'b0;
        #1;
        n_total++;
        if (sentido !== 2'd0 || giro_pendente !== 1'b0 || giro_descartado !== 1'b0)
            $display("FAIL reset_state: got %0d/%0b/%0b, expected 0/0/0", sentido, giro_pendente, giro_descartado);
        else n_pass++;
        hard_reset();
        test_reset();
        test_bounce();
        test_wrap();
        test_overflow();
        test_simultaneous();
        test_restart();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
